sevenseg_frame_serializer: RTL
==============================

Name: sevenseg_frame_serializer

Overview:
- Transmit end of the serial-bit + 3-bit-select segment link consumed by the 1x8 segment demux.
- Captures one 8-bit segment frame (Seg0..Seg6, SegDP) and replays it one bit per select slot.
- Drives `out` (the demux data input) and `S[2:0]` (the demux select) over eight consecutive slots, with a valid/ready load handshake on the parallel side.
- Sits between display-pattern logic and the segment demux.

Parameters:
- DIV, 4: clock cycles per select slot. Legal range 1..256.
- ACTIVE_LOW, 0:
  - 0: `seg_in` bit=1 means the segment is lit.
  - 1: `seg_in` is active-low (0 = lit) and is inverted at capture.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load_valid  input  1  `seg_in` holds a frame to send.
- load_ready  output  1  block accepts a frame this cycle.
- seg_in  input  8  frame: bit0=Seg0 … bit6=Seg6, bit7=SegDP.
- out  output  1  serial segment bit (1 = lit) for the current slot.
- S  output  3  slot/segment index 0..7.
- frame_start  output  1  one-cycle pulse in the first cycle of slot 0.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse in the last cycle of slot 7.

Behaviour:
- All outputs are registered. Reset values:
  - out=0, S=0, busy=0, frame_start=0, done=0, load_ready=0.
  - State = IDLE; internal frame register and slot counter = 0.
- First rising edge after `rst` deasserts: load_ready goes to 1. `load_valid` is ignored while rst=1.
- States:
  - IDLE:
    - load_ready=1, busy=0, out=0 (demux input low, all segments dark), S holds 0.
    - A transfer occurs on a clock edge where load_valid & load_ready.
    - On transfer: frame_reg <= ACTIVE_LOW ? ~seg_in : seg_in; S<=0; slot cnt<=0.
    - Next cycle: busy=1, out=frame_reg[0], frame_start=1. Go to SHIFT.
  - SHIFT:
    - `out` always equals frame_reg[S].
    - cnt counts 0..DIV-1. At cnt==DIV-1 with S<7: S<=S+1, cnt<=0.
    - At cnt==DIV-1 with S==7 (last frame cycle): done=1 and load_ready=1 in that cycle (registered one cycle ahead).
      - load_valid=1: capture the new frame, S<=0, cnt<=0, frame_start next cycle, remain in SHIFT. No idle gap; busy stays 1.
      - load_valid=0: go to IDLE, out<=0, S<=0, busy<=0.
    - All other SHIFT cycles: load_ready=0. `seg_in` and `load_valid` are ignored; frame_reg is never altered mid-frame.
- Latency and duration:
  - Transfer edge to first `out` bit: 1 cycle.
  - Frame duration: exactly 8*DIV cycles from frame_start to the end of the done cycle.
- DIV=1: every cycle is a new slot. frame_start and done never coincide (slot 0 ≠ slot 7).
- S wraps only via a new frame load or a return to IDLE; it never counts past 7.
- Async reset mid-frame: all outputs go to reset values immediately. The partial frame is discarded and never resumed.
- The cnt width covers DIV-1 and must synthesize correctly for DIV=1 (minimum width 1).

Test Plan:
- Reset: assert rst mid-simulation → out=0, S=0, busy=0, load_ready=0 asynchronously. load_ready=1 one edge after release.
- Single frame: DIV=4, ACTIVE_LOW=0, seg_in=8'hA5, load_valid for one cycle →
  - `out` = 1,0,1,0,0,1,0,1 for S=0..7, each held 4 cycles.
  - frame_start at cycle 1; done at cycle 32; then IDLE with out=0.
- Back-to-back: frames 8'hFF then 8'h01 (second load_valid held high) →
  - 8'hFF ends with done; next cycle frame_start, S=0, out=1, busy stays 1.
  - Then out=0 for S=1..7.
- Busy-ignore: load 8'h0F, then pulse load_valid with seg_in=8'hF0 at slot 3 → no effect; 8'h0F is sent intact, load_ready=0 during the pulse.
- Active-low/DIV=1: ACTIVE_LOW=1, DIV=1, seg_in=8'hFE → out=1 only at S=0; 8-cycle frame; S increments every cycle.
- Reset mid-frame: rst at slot 5 → immediate reset values. A fresh load of 8'h80 afterwards → out=1 only at S=7.

Source files
------------

// File: rtl/sevenseg_frame_serializer_if.sv
// Parallel load handshake plus serial segment/select outputs of the frame serializer.
// The master side loads frames; the slave side (the serializer) drives the demux link.
interface sevenseg_frame_serializer_if;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] seg_in;
   logic       out;
   logic [2:0] S;
   logic       frame_start;
   logic       busy;
   logic       done;

   modport master (
      output load_valid, seg_in,
      input  load_ready, out, S, frame_start, busy, done
   );

   modport slave (
      input  load_valid, seg_in,
      output load_ready, out, S, frame_start, busy, done
   );
endinterface

// File: rtl/sevenseg_frame_serializer.sv
// Captures an 8-bit segment frame and replays it one bit per select slot (DIV cycles each)
// on the serial-bit + 3-bit-select link feeding the 1x8 segment demux.
module sevenseg_frame_serializer #(
   parameter int unsigned DIV        = 4,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input logic                        clk,
   input logic                        rst,
   sevenseg_frame_serializer_if.slave bus
);

   localparam int unsigned     CntW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

   typedef enum logic {StIdle, StShift} state_e;

   state_e          state_q, state_d;
   logic [7:0]      frame_q, frame_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      s_q, s_d;
   logic            out_q, out_d;
   logic            busy_q, busy_d;
   logic            start_q, start_d;
   logic            done_q, done_d;
   logic            ready_q, ready_d;

   logic [7:0]      captured;
   logic            transfer;
   logic            last_cycle;

   // Frame is stored in lit-high polarity so out never needs inverting.
   assign captured   = ACTIVE_LOW ? ~bus.seg_in : bus.seg_in;
   assign transfer   = bus.load_valid & ready_q;
   assign last_cycle = (state_q == StShift) && (cnt_q == CntMax) && (s_q == 3'd7);

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      out_d   = 1'b0;
      busy_d  = 1'b0;
      start_d = 1'b0;
      done_d  = 1'b0;
      ready_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            ready_d = 1'b1;
            s_d     = 3'd0;
            cnt_d   = '0;
            if (transfer) begin
               frame_d = captured;
               state_d = StShift;
               busy_d  = 1'b1;
               out_d   = captured[0];
               start_d = 1'b1;
               ready_d = 1'b0;
            end
         end

         StShift: begin
            busy_d = 1'b1;
            if (last_cycle) begin
               s_d   = 3'd0;
               cnt_d = '0;
               if (transfer) begin
                  frame_d = captured;
                  out_d   = captured[0];
                  start_d = 1'b1;
               end else begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
                  ready_d = 1'b1;
               end
            end else begin
               if (cnt_q == CntMax) begin
                  s_d   = s_q + 3'd1;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
               out_d   = frame_q[s_d];
               // Flag the upcoming last cycle so done/load_ready are registered in time.
               done_d  = (cnt_d == CntMax) && (s_d == 3'd7);
               ready_d = done_d;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         frame_q <= 8'h00;
         cnt_q   <= '0;
         s_q     <= 3'd0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         start_q <= start_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign bus.load_ready  = ready_q;
   assign bus.out         = out_q;
   assign bus.S           = s_q;
   assign bus.frame_start = start_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule
